// File: rtl/qspi_top_core.sv
// qspi_top_core: SPI/QSPI slave giving an external host access to a mode
// register (reg0, bit0 = qpi_en), a 32-bit GPIO register and two core
// status bits. All host pins are synchronised into clk_i and decoded there.
module qspi_top_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic        en_ifetch_i,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic [1:0]  spi_mode,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [31:0] gpio_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_WR_REG0   = 8'h01;
  localparam logic [7:0] CMD_WR_GPIO   = 8'h02;
  localparam logic [7:0] CMD_RD_REG0   = 8'h05;
  localparam logic [7:0] CMD_RD_GPIO   = 8'h07;
  localparam logic [7:0] CMD_RD_STATUS = 8'h09;

  // Synchroniser stages; sclk, cs and sdi all see the same depth so the
  // data nibble stays aligned with the detected sclk edge.
  logic [1:0]  r_sclkSync;
  logic [1:0]  r_csSync;
  logic [3:0]  r_sdiSync0;
  logic [3:0]  r_sdiSync1;
  logic        r_sclkPrev;

  // Transfer state
  state_t      r_state;
  logic [5:0]  r_bitCnt;
  logic [5:0]  r_len;
  logic        r_wrGpio;
  logic [31:0] r_shift;
  logic [31:0] r_rdShift;
  logic [7:0]  r_reg0;
  logic [31:0] r_gpio;
  logic [3:0]  r_sdo;
  logic [1:0]  r_mode;

  logic        w_sclkRise;
  logic        w_sclkFall;
  logic        w_csHigh;
  logic [3:0]  w_sdi;
  logic        w_quad;
  logic [5:0]  w_step;
  logic [5:0]  w_nextCnt;
  logic [31:0] w_shiftIn;

  assign w_sclkRise = r_sclkSync[1] & ~r_sclkPrev;
  assign w_sclkFall = ~r_sclkSync[1] & r_sclkPrev;
  assign w_csHigh   = r_csSync[1];
  assign w_sdi      = r_sdiSync1;
  assign w_quad     = r_reg0[0];
  assign w_step     = w_quad ? 6'd4 : 6'd1;
  assign w_nextCnt  = r_bitCnt + w_step;
  assign w_shiftIn  = w_quad ? {r_shift[27:0], w_sdi} : {r_shift[30:0], w_sdi[0]};

  assign spi_mode = r_mode;
  assign spi_sdo0 = r_sdo[0];
  assign spi_sdo1 = r_sdo[1];
  assign spi_sdo2 = r_sdo[2];
  assign spi_sdo3 = r_sdo[3];
  assign gpio_o   = r_gpio;

  // Two-flop synchronisers plus the delayed sclk used for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclkSync <= 2'b00;
      r_csSync   <= 2'b11;
      r_sdiSync0 <= 4'h0;
      r_sdiSync1 <= 4'h0;
      r_sclkPrev <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[0], spi_sclk};
      r_csSync   <= {r_csSync[0], spi_cs};
      r_sdiSync0 <= {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0};
      r_sdiSync1 <= r_sdiSync0;
      r_sclkPrev <= r_sclkSync[1];
    end
  end

  // Transfer FSM: command decode, register writes, read shifting and pad mode.
  // A high chip select is checked first so it wins over any pending sclk edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_bitCnt  <= 6'd0;
      r_len     <= 6'd0;
      r_wrGpio  <= 1'b0;
      r_shift   <= 32'h0;
      r_rdShift <= 32'h0;
      r_reg0    <= 8'h00;
      r_gpio    <= 32'h0;
      r_sdo     <= 4'h0;
      r_mode    <= 2'd0;
    end else begin
      if (!r_reg0[0]) begin
        r_mode <= 2'd0;
      end else if (r_state == ST_RDATA) begin
        r_mode <= 2'd1;
      end else begin
        r_mode <= 2'd2;
      end

      if (w_csHigh) begin
        r_state  <= ST_IDLE;
        r_bitCnt <= 6'd0;
        r_sdo    <= 4'h0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_CMD;
            r_bitCnt <= 6'd0;
            r_shift  <= 32'h0;
            r_sdo    <= 4'h0;
          end
          ST_CMD: begin
            if (w_sclkRise) begin
              r_shift <= w_shiftIn;
              if (w_nextCnt >= 6'd8) begin
                r_bitCnt <= 6'd0;
                case (w_shiftIn[7:0])
                  CMD_WR_REG0: begin
                    r_state  <= ST_WDATA;
                    r_len    <= 6'd8;
                    r_wrGpio <= 1'b0;
                  end
                  CMD_WR_GPIO: begin
                    r_state  <= ST_WDATA;
                    r_len    <= 6'd32;
                    r_wrGpio <= 1'b1;
                  end
                  CMD_RD_REG0: begin
                    r_state   <= ST_RDATA;
                    r_len     <= 6'd8;
                    r_rdShift <= {r_reg0, 24'h0};
                  end
                  CMD_RD_GPIO: begin
                    r_state   <= ST_RDATA;
                    r_len     <= 6'd32;
                    r_rdShift <= r_gpio;
                  end
                  CMD_RD_STATUS: begin
                    r_state   <= ST_RDATA;
                    r_len     <= 6'd8;
                    r_rdShift <= {6'b0, en_ifetch_i, fetch_enable_i, 24'h0};
                  end
                  default: begin
                    r_state <= ST_IGNORE;
                  end
                endcase
              end else begin
                r_bitCnt <= w_nextCnt;
              end
            end
          end
          ST_WDATA: begin
            if (w_sclkRise) begin
              r_shift <= w_shiftIn;
              if (w_nextCnt >= r_len) begin
                if (r_wrGpio) begin
                  r_gpio <= w_shiftIn;
                end else begin
                  r_reg0 <= w_shiftIn[7:0];
                end
                r_state <= ST_IGNORE;
              end else begin
                r_bitCnt <= w_nextCnt;
              end
            end
          end
          ST_RDATA: begin
            if (w_sclkFall) begin
              if (r_bitCnt < r_len) begin
                if (w_quad) begin
                  r_sdo     <= r_rdShift[31:28];
                  r_rdShift <= {r_rdShift[27:0], 4'h0};
                end else begin
                  r_sdo     <= {3'b000, r_rdShift[31]};
                  r_rdShift <= {r_rdShift[30:0], 1'b0};
                end
                r_bitCnt <= w_nextCnt;
              end else begin
                r_sdo   <= 4'h0;
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_IGNORE: begin
            r_sdo <= 4'h0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_top_core.sv
// tb_qspi_top_core: drives SPI/QSPI host transfers into qspi_top_core and
// checks read data, pad mode and GPIO through a scoreboard queue drained by
// an independent monitor process.
module tb_qspi_top_core;

  logic        clk;
  logic        rst;
  logic        fetchEnable;
  logic        enIfetch;
  logic        spiSclk;
  logic        spiCs;
  logic [1:0]  spiMode;
  logic        sdi0, sdi1, sdi2, sdi3;
  logic        sdo0, sdo1, sdo2, sdo3;
  logic [31:0] gpio;

  localparam int KIND_SDO  = 0;
  localparam int KIND_GPIO = 1;
  localparam int KIND_MODE = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] expVal;
  } chk_t;

  chk_t expQ[$];
  event sampleReq;
  int   checks;
  int   failures;

  qspi_top_core dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fetchEnable),
    .en_ifetch_i    (enIfetch),
    .spi_sclk       (spiSclk),
    .spi_cs         (spiCs),
    .spi_mode       (spiMode),
    .spi_sdi0       (sdi0),
    .spi_sdi1       (sdi1),
    .spi_sdi2       (sdi2),
    .spi_sdi3       (sdi3),
    .spi_sdo0       (sdo0),
    .spi_sdo1       (sdo1),
    .spi_sdo2       (sdo2),
    .spi_sdo3       (sdo3),
    .gpio_o         (gpio)
  );

  // System clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a visible failure
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: whenever the host side asks for a sample, pop every pending
  // expectation and compare it against what the DUT currently presents
  initial begin
    chk_t        c;
    logic [31:0] act;
    checks   = 0;
    failures = 0;
    forever begin
      @(sampleReq);
      while (expQ.size() > 0) begin
        c = expQ.pop_front();
        case (c.kind)
          KIND_SDO:  act = {28'h0, sdo3, sdo2, sdo1, sdo0};
          KIND_GPIO: act = gpio;
          default:   act = {30'h0, spiMode};
        endcase
        checks++;
        if (act !== c.expVal) begin
          failures++;
          $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.expVal);
        end
      end
    end
  end

  // Queue one expectation and wake the monitor
  task automatic checkOutput(input string name, input int kind, input logic [31:0] expVal);
    chk_t c;
    c.name   = name;
    c.kind   = kind;
    c.expVal = expVal;
    expQ.push_back(c);
    -> sampleReq;
  endtask

  // Clock nBits of word (right aligned, MSB first) across the link. For reads
  // the word is the expected response, checked at each sclk rise.
  task automatic sendBits(input logic [31:0] word, input int nBits, input bit quad,
                          input bit isRead, input int expMode, input int modeAfterLast,
                          input string name);
    int         step;
    int         n;
    int         pos;
    logic [3:0] unit;
    step = quad ? 4 : 1;
    n    = nBits / step;
    for (int i = 0; i < n; i++) begin
      pos = nBits - 1 - i * step;
      if (quad) unit = word[pos -: 4];
      else      unit = {3'b000, word[pos]};
      {sdi3, sdi2, sdi1, sdi0} = isRead ? 4'h0 : unit;
      repeat (5) @(negedge clk);
      spiSclk = 1'b1;
      if (isRead) begin
        checkOutput($sformatf("%s_u%0d", name, i), KIND_SDO, {28'h0, unit});
        if (expMode >= 0)
          checkOutput($sformatf("%s_mode%0d", name, i), KIND_MODE, expMode);
      end
      repeat (4) @(negedge clk);
      if (i == n - 1 && modeAfterLast >= 0)
        checkOutput($sformatf("%s_modeLast", name), KIND_MODE, modeAfterLast);
      @(negedge clk);
      spiSclk = 1'b0;
    end
  endtask

  // One full transfer: cs low, command byte, data phase, then for reads one
  // extra sclk that must see idle (zero) sdo lines, then cs high
  task automatic applyStimulus(input logic [7:0] cmd, input bit quad, input int nData,
                               input logic [31:0] data, input bit isRead,
                               input int modeAfterLast, input string name);
    spiCs = 1'b0;
    repeat (5) @(negedge clk);
    sendBits({24'h0, cmd}, 8, quad, 1'b0, -1, -1, name);
    if (nData > 0)
      sendBits(data, nData, quad, isRead, isRead ? (quad ? 1 : 0) : -1, modeAfterLast, name);
    if (isRead)
      sendBits(32'h0, quad ? 4 : 1, quad, 1'b1, quad ? 2 : 0, -1, {name, "_tail"});
    repeat (5) @(negedge clk);
    spiCs = 1'b1;
    {sdi3, sdi2, sdi1, sdi0} = 4'h0;
    repeat (8) @(negedge clk);
  endtask

  // Main directed sequence
  initial begin
    rst         = 1'b1;
    spiCs       = 1'b1;
    spiSclk     = 1'b0;
    fetchEnable = 1'b0;
    enIfetch    = 1'b0;
    {sdi3, sdi2, sdi1, sdi0} = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mode", KIND_MODE, 32'd0);
    checkOutput("rst_gpio", KIND_GPIO, 32'h0);
    checkOutput("rst_sdo",  KIND_SDO,  32'h0);
    repeat (4) @(negedge clk);

    // Standard write of reg0=0x01 switches the link into quad mode
    applyStimulus(8'h01, 1'b0, 8, 32'h01, 1'b0, 2, "wrReg0Std");
    checkOutput("wrReg0Std_modeAfterCs", KIND_MODE, 32'd2);

    // Quad GPIO write then read back
    applyStimulus(8'h02, 1'b1, 32, 32'hDEADBEEF, 1'b0, -1, "wrGpioQuad");
    checkOutput("wrGpioQuad_gpio", KIND_GPIO, 32'hDEADBEEF);
    checkOutput("wrGpioQuad_mode", KIND_MODE, 32'd2);
    applyStimulus(8'h07, 1'b1, 32, 32'hDEADBEEF, 1'b1, -1, "rdGpioQuad");
    checkOutput("rdGpioQuad_modeAfterCs", KIND_MODE, 32'd2);
    applyStimulus(8'h05, 1'b1, 8, 32'h01, 1'b1, -1, "rdReg0Quad");

    // Clearing reg0 in quad mode returns the pads to standard mode
    applyStimulus(8'h01, 1'b1, 8, 32'h00, 1'b0, 0, "wrReg0Quad");
    checkOutput("wrReg0Quad_mode", KIND_MODE, 32'd0);
    applyStimulus(8'h05, 1'b0, 8, 32'h00, 1'b1, -1, "rdReg0Std");

    // Status reads with both bit orderings
    fetchEnable = 1'b1;
    enIfetch    = 1'b0;
    applyStimulus(8'h09, 1'b0, 8, 32'h01, 1'b1, -1, "rdStatus01");
    fetchEnable = 1'b0;
    enIfetch    = 1'b1;
    applyStimulus(8'h09, 1'b0, 8, 32'h02, 1'b1, -1, "rdStatus02");
    enIfetch    = 1'b0;

    // Aborted GPIO write leaves the register untouched
    applyStimulus(8'h02, 1'b0, 20, 32'h12345, 1'b0, -1, "wrGpioPartial");
    checkOutput("wrGpioPartial_gpio", KIND_GPIO, 32'hDEADBEEF);

    // Upper reg0 bits are stored; qpi_en stays clear
    applyStimulus(8'h01, 1'b0, 8, 32'hA4, 1'b0, 0, "wrReg0A4");
    checkOutput("wrReg0A4_mode", KIND_MODE, 32'd0);

    // Unknown command with trailing clocks changes nothing
    applyStimulus(8'hFF, 1'b0, 8, 32'h03, 1'b0, -1, "unknownCmd");
    checkOutput("unknownCmd_mode", KIND_MODE, 32'd0);
    checkOutput("unknownCmd_gpio", KIND_GPIO, 32'hDEADBEEF);
    applyStimulus(8'h05, 1'b0, 8, 32'hA4, 1'b1, -1, "rdReg0A4");

    // Standard-mode GPIO read
    applyStimulus(8'h07, 1'b0, 32, 32'hDEADBEEF, 1'b1, -1, "rdGpioStd");

    // Flush the monitor and make sure every expectation was consumed
    repeat (5) @(negedge clk);
    -> sampleReq;
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
